// File: rtl/rx_cmd_pkg.sv
// Shared constants and state encoding for the UART command-frame decoder.
// Opcodes are the first byte of every frame; operand addresses feed the ALU.
package rx_cmd_pkg;

    localparam logic [7:0] WR_CMD      = 8'hAA;
    localparam logic [7:0] RD_CMD      = 8'hBB;
    localparam logic [7:0] ALU_OP_CMD  = 8'hCC;
    localparam logic [7:0] ALU_NOP_CMD = 8'hDD;

    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_ALU_A   = 3'd4,
        ST_ALU_B   = 3'd5,
        ST_ALU_FUN = 3'd6
    } cmd_state_e;

endpackage

// File: rtl/frame_timeout_cnt.sv
// Inter-byte watchdog: counts idle cycles inside a frame and flags expiry
// on the cycle the count sits at TIMEOUT_CYCLES-1.
module frame_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // A clear in the expiry cycle means a byte arrived in time; no expiry.
    assign expire = run && !clear && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || expire) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rx_cmd_decoder.sv
// Assembles UART bytes into command frames and issues one-cycle register-file
// and ALU strobes; aborts on bad bytes, unknown opcodes or inter-byte timeout.
module rx_cmd_decoder
    import rx_cmd_pkg::*;
#(
    parameter int DATA_LENGTH    = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   CLK_CMD,
    input  logic                   RST_CMD,
    input  logic [DATA_LENGTH-1:0] P_DATA_CMD,
    input  logic                   data_valid_CMD,
    input  logic                   parity_error_CMD,
    input  logic                   stop_error_CMD,
    output logic                   WrEn_CMD,
    output logic                   RdEn_CMD,
    output logic [ADDR_WIDTH-1:0]  Address_CMD,
    output logic [DATA_LENGTH-1:0] WrData_CMD,
    output logic                   ALU_EN_CMD,
    output logic [3:0]             ALU_FUN_CMD,
    output logic                   frame_err_CMD,
    output logic                   cmd_busy_CMD
);

    cmd_state_e state, state_d;

    logic byte_ok, byte_bad, expire;
    logic wr_d, rd_d, alu_d, ferr_d;
    logic [ADDR_WIDTH-1:0]  addr_lat, addr_lat_d, addr_d;
    logic [DATA_LENGTH-1:0] wdata_d;
    logic [3:0]             fun_d;

    assign byte_ok  = data_valid_CMD && !parity_error_CMD && !stop_error_CMD;
    assign byte_bad = data_valid_CMD && (parity_error_CMD || stop_error_CMD);

    frame_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (CLK_CMD),
        .rst_n  (RST_CMD),
        .clear  (byte_ok || (state == ST_IDLE)),
        .run    (state != ST_IDLE),
        .expire (expire)
    );

    always_ff @(posedge CLK_CMD or negedge RST_CMD) begin
        if (!RST_CMD) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d    = state;
        addr_lat_d = addr_lat;
        addr_d     = Address_CMD;
        wdata_d    = WrData_CMD;
        fun_d      = ALU_FUN_CMD;
        wr_d       = 1'b0;
        rd_d       = 1'b0;
        alu_d      = 1'b0;
        ferr_d     = 1'b0;

        if (state == ST_IDLE) begin
            // Errored bytes between frames are silently dropped.
            if (byte_ok) begin
                if (P_DATA_CMD == DATA_LENGTH'(WR_CMD)) begin
                    state_d = ST_WR_ADDR;
                end else if (P_DATA_CMD == DATA_LENGTH'(RD_CMD)) begin
                    state_d = ST_RD_ADDR;
                end else if (P_DATA_CMD == DATA_LENGTH'(ALU_OP_CMD)) begin
                    state_d = ST_ALU_A;
                end else if (P_DATA_CMD == DATA_LENGTH'(ALU_NOP_CMD)) begin
                    state_d = ST_ALU_FUN;
                end else begin
                    ferr_d = 1'b1;
                end
            end
        end else if (byte_ok) begin
            // A good byte always beats a coincident timeout expiry.
            case (state)
                ST_WR_ADDR: begin
                    addr_lat_d = P_DATA_CMD[ADDR_WIDTH-1:0];
                    state_d    = ST_WR_DATA;
                end
                ST_WR_DATA: begin
                    wr_d    = 1'b1;
                    addr_d  = addr_lat;
                    wdata_d = P_DATA_CMD;
                    state_d = ST_IDLE;
                end
                ST_RD_ADDR: begin
                    rd_d    = 1'b1;
                    addr_d  = P_DATA_CMD[ADDR_WIDTH-1:0];
                    state_d = ST_IDLE;
                end
                ST_ALU_A: begin
                    wr_d    = 1'b1;
                    addr_d  = ADDR_WIDTH'(OPA_ADDR);
                    wdata_d = P_DATA_CMD;
                    state_d = ST_ALU_B;
                end
                ST_ALU_B: begin
                    wr_d    = 1'b1;
                    addr_d  = ADDR_WIDTH'(OPB_ADDR);
                    wdata_d = P_DATA_CMD;
                    state_d = ST_ALU_FUN;
                end
                ST_ALU_FUN: begin
                    alu_d   = 1'b1;
                    fun_d   = P_DATA_CMD[3:0];
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (byte_bad || expire) begin
            state_d = ST_IDLE;
            ferr_d  = 1'b1;
        end
    end

    always_ff @(posedge CLK_CMD or negedge RST_CMD) begin
        if (!RST_CMD) begin
            WrEn_CMD      <= 1'b0;
            RdEn_CMD      <= 1'b0;
            ALU_EN_CMD    <= 1'b0;
            frame_err_CMD <= 1'b0;
            cmd_busy_CMD  <= 1'b0;
            Address_CMD   <= '0;
            WrData_CMD    <= '0;
            ALU_FUN_CMD   <= '0;
            addr_lat      <= '0;
        end else begin
            WrEn_CMD      <= wr_d;
            RdEn_CMD      <= rd_d;
            ALU_EN_CMD    <= alu_d;
            frame_err_CMD <= ferr_d;
            cmd_busy_CMD  <= (state_d != ST_IDLE);
            Address_CMD   <= addr_d;
            WrData_CMD    <= wdata_d;
            ALU_FUN_CMD   <= fun_d;
            addr_lat      <= addr_lat_d;
        end
    end

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// Bench for rx_cmd_decoder: two instances (long and 16-cycle timeout) driven
// in parallel and compared each cycle against a frame-level reference model.
module tb_rx_cmd_decoder;

    localparam int TA = 4096;
    localparam int TT = 16;

    typedef struct packed {
        logic       v;
        logic       p;
        logic       s;
        logic [7:0] x;
    } stim_t;

    typedef struct packed {
        logic [3:0][7:0] b;
        logic [2:0]      n;
        logic [15:0]     gap;
        logic [3:0]      addr;
        logic [7:0]      wdata;
        logic [3:0]      fun;
        logic            wr;
        logic            rd;
        logic            alu;
        logic            ferr;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dv = 1'b0, pe = 1'b0, se = 1'b0;
    logic [7:0] d = 8'h00;

    logic       wr_a, rd_a, alu_a, fe_a, busy_a;
    logic [3:0] addr_a, fun_a;
    logic [7:0] wd_a;
    logic       wr_t, rd_t, alu_t, fe_t, busy_t;
    logic [3:0] addr_t, fun_t;
    logic [7:0] wd_t;

    int checks = 0;
    int errors = 0;
    mdl_t ma, mt;

    always #5 clk = ~clk;

    rx_cmd_decoder #(.DATA_LENGTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(TA)) dut_a (
        .CLK_CMD(clk), .RST_CMD(rst_n), .P_DATA_CMD(d), .data_valid_CMD(dv),
        .parity_error_CMD(pe), .stop_error_CMD(se), .WrEn_CMD(wr_a), .RdEn_CMD(rd_a),
        .Address_CMD(addr_a), .WrData_CMD(wd_a), .ALU_EN_CMD(alu_a), .ALU_FUN_CMD(fun_a),
        .frame_err_CMD(fe_a), .cmd_busy_CMD(busy_a)
    );

    rx_cmd_decoder #(.DATA_LENGTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(TT)) dut_t (
        .CLK_CMD(clk), .RST_CMD(rst_n), .P_DATA_CMD(d), .data_valid_CMD(dv),
        .parity_error_CMD(pe), .stop_error_CMD(se), .WrEn_CMD(wr_t), .RdEn_CMD(rd_t),
        .Address_CMD(addr_t), .WrData_CMD(wd_t), .ALU_EN_CMD(alu_t), .ALU_FUN_CMD(fun_t),
        .frame_err_CMD(fe_t), .cmd_busy_CMD(busy_t)
    );

    wire [20:0] obs_a = {wr_a, rd_a, alu_a, fe_a, busy_a, addr_a, wd_a, fun_a};
    wire [20:0] obs_t = {wr_t, rd_t, alu_t, fe_t, busy_t, addr_t, wd_t, fun_t};

    // Frame length in bytes including the opcode; 0 for an unknown opcode.
    function automatic int flen(input logic [7:0] op);
        case (op)
            8'hAA:   return 3;
            8'hBB:   return 2;
            8'hCC:   return 4;
            8'hDD:   return 2;
            default: return 0;
        endcase
    endfunction

    // Reference: collect bytes of the current frame, act on byte position.
    function automatic mdl_t mdl_step(input mdl_t m, input int tmo, input logic v,
                                      input logic p, input logic s, input logic [7:0] x);
        mdl_t r;
        logic ok;
        int   k;
        r = m;
        ok = v && !p && !s;
        r.wr = 1'b0; r.rd = 1'b0; r.alu = 1'b0; r.ferr = 1'b0;
        if (m.n == 3'd0) begin
            r.gap = 16'd0;
            if (ok) begin
                if (flen(x) != 0) begin
                    r.b[0] = x;
                    r.n = 3'd1;
                end else begin
                    r.ferr = 1'b1;
                end
            end
        end else if (ok) begin
            k = int'(m.n);
            r.b[k] = x;
            r.gap = 16'd0;
            case (m.b[0])
                8'hAA: if (k == 2) begin r.wr = 1'b1; r.addr = m.b[1][3:0]; r.wdata = x; end
                8'hBB: begin r.rd = 1'b1; r.addr = x[3:0]; end
                8'hCC: begin
                    if (k == 1) begin r.wr = 1'b1; r.addr = 4'd0; r.wdata = x; end
                    else if (k == 2) begin r.wr = 1'b1; r.addr = 4'd1; r.wdata = x; end
                    else begin r.alu = 1'b1; r.fun = x[3:0]; end
                end
                default: begin r.alu = 1'b1; r.fun = x[3:0]; end
            endcase
            r.n = (k + 1 == flen(m.b[0])) ? 3'd0 : 3'(k + 1);
        end else if (v) begin
            r.n = 3'd0;
            r.ferr = 1'b1;
        end else begin
            r.gap = m.gap + 16'd1;
            if (int'(r.gap) == tmo) begin
                r.n = 3'd0;
                r.gap = 16'd0;
                r.ferr = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [20:0] pack(input mdl_t m);
        return {m.wr, m.rd, m.alu, m.ferr, (m.n != 3'd0), m.addr, m.wdata, m.fun};
    endfunction

    function automatic stim_t B(input logic [7:0] x);
        return {1'b1, 1'b0, 1'b0, x};
    endfunction

    localparam stim_t IDL = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= '0;
            mt <= '0;
        end else begin
            ma <= mdl_step(ma, TA, dv, pe, se, d);
            mt <= mdl_step(mt, TT, dv, pe, se, d);
        end
    end

    // Called at a negedge; returns at the following negedge.
    task automatic cyc(input stim_t st);
        dv = st.v; pe = st.p; se = st.s; d = st.x;
        @(posedge clk);
        @(negedge clk);
        dv = 1'b0; pe = 1'b0; se = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (obs_a !== 21'd0 || obs_t !== 21'd0) begin
            errors++;
            $display("FAIL reset_values: got %h/%h want 0", obs_a, obs_t);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_slow();
        stim_t q[$];
        int ferr_a = 0;
        q.push_back(B(8'hAA));
        repeat (39) q.push_back(IDL);
        q.push_back(B(8'h05));
        repeat (39) q.push_back(IDL);
        q.push_back(B(8'h3C));
        foreach (q[i]) begin
            cyc(q[i]);
            if (fe_a) ferr_a++;
            checks++;
            if (obs_a !== pack(ma)) begin errors++; $display("FAIL write_slow a[%0d]: got %h want %h", i, obs_a, pack(ma)); end
            checks++;
            if (obs_t !== pack(mt)) begin errors++; $display("FAIL write_slow t[%0d]: got %h want %h", i, obs_t, pack(mt)); end
        end
        checks++;
        if ({wr_a, addr_a, wd_a} !== {1'b1, 4'h5, 8'h3C} || ferr_a != 0) begin
            errors++;
            $display("FAIL write_slow_strobe: got wr=%b addr=%h data=%h ferr=%0d want 1/5/3c/0", wr_a, addr_a, wd_a, ferr_a);
        end
    endtask

    task automatic test_frames();
        stim_t q[$];
        int nwr = 0, nrd = 0, nalu = 0;
        // read with gap, ALU op, ALU nop, then back-to-back frames
        q.push_back(B(8'hBB)); q.push_back(IDL); q.push_back(IDL); q.push_back(B(8'h09));
        q.push_back(B(8'hCC)); q.push_back(B(8'h12)); q.push_back(IDL); q.push_back(B(8'h34));
        q.push_back(B(8'h02)); q.push_back(IDL); q.push_back(B(8'hDD)); q.push_back(B(8'h07));
        q.push_back(B(8'hBB)); q.push_back(B(8'h01)); q.push_back(B(8'hAA)); q.push_back(B(8'h02));
        q.push_back(B(8'h03)); q.push_back(B(8'hDD)); q.push_back(B(8'hFA)); q.push_back(IDL);
        foreach (q[i]) begin
            cyc(q[i]);
            nwr += int'(wr_a); nrd += int'(rd_a); nalu += int'(alu_a);
            checks++;
            if (obs_a !== pack(ma)) begin errors++; $display("FAIL frames a[%0d]: got %h want %h", i, obs_a, pack(ma)); end
            checks++;
            if (obs_t !== pack(mt)) begin errors++; $display("FAIL frames t[%0d]: got %h want %h", i, obs_t, pack(mt)); end
            if (i == 8) begin
                checks++;
                if ({alu_a, fun_a} !== {1'b1, 4'h2}) begin errors++; $display("FAIL alu_fun2: got %b/%h want 1/2", alu_a, fun_a); end
            end
        end
        checks++;
        if (nwr != 3 || nrd != 2 || nalu != 3) begin
            errors++;
            $display("FAIL strobe_counts: got wr=%0d rd=%0d alu=%0d want 3/2/3", nwr, nrd, nalu);
        end
        checks++;
        if ({alu_a, fun_a, busy_a} !== {1'b0, 4'hA, 1'b0}) begin
            errors++;
            $display("FAIL fun_hold: got alu=%b fun=%h busy=%b want 0/a/0", alu_a, fun_a, busy_a);
        end
    endtask

    task automatic test_errors();
        stim_t q[$];
        q.push_back(B(8'h55));
        q.push_back({1'b1, 1'b0, 1'b1, 8'hAA});
        q.push_back(B(8'hAA));
        q.push_back({1'b1, 1'b1, 1'b0, 8'h07});
        q.push_back(B(8'hAA)); q.push_back(B(8'h01)); q.push_back(B(8'hFF));
        foreach (q[i]) begin
            cyc(q[i]);
            checks++;
            if (obs_a !== pack(ma)) begin errors++; $display("FAIL errors a[%0d]: got %h want %h", i, obs_a, pack(ma)); end
            checks++;
            if (obs_t !== pack(mt)) begin errors++; $display("FAIL errors t[%0d]: got %h want %h", i, obs_t, pack(mt)); end
            if (i == 0 || i == 3) begin
                checks++;
                if ({fe_a, busy_a, wr_a} !== 3'b100) begin errors++; $display("FAIL err_pulse[%0d]: got fe/busy/wr=%b%b%b want 100", i, fe_a, busy_a, wr_a); end
            end
        end
        checks++;
        if ({wr_a, addr_a, wd_a} !== {1'b1, 4'h1, 8'hFF}) begin
            errors++;
            $display("FAIL recover_write: got %b/%h/%h want 1/1/ff", wr_a, addr_a, wd_a);
        end
    endtask

    task automatic test_timeout();
        stim_t q[$];
        q.push_back(B(8'hAA)); repeat (20) q.push_back(IDL);
        q.push_back(B(8'hAA)); repeat (15) q.push_back(IDL); q.push_back(B(8'h05)); q.push_back(B(8'h3C));
        q.push_back(B(8'hAA)); repeat (15) q.push_back(IDL); q.push_back({1'b1, 1'b1, 1'b0, 8'h11});
        repeat (5) q.push_back(IDL);
        foreach (q[i]) begin
            cyc(q[i]);
            checks++;
            if (obs_a !== pack(ma)) begin errors++; $display("FAIL timeout a[%0d]: got %h want %h", i, obs_a, pack(ma)); end
            checks++;
            if (obs_t !== pack(mt)) begin errors++; $display("FAIL timeout t[%0d]: got %h want %h", i, obs_t, pack(mt)); end
            checks++;
            if (fe_t !== (i == 16 || i == 55)) begin errors++; $display("FAIL timeout_pulse[%0d]: got %b want %b", i, fe_t, (i == 16 || i == 55)); end
            if (i == 38) begin
                checks++;
                if ({wr_t, addr_t, wd_t} !== {1'b1, 4'h5, 8'h3C}) begin errors++; $display("FAIL expiry_byte_wins: got %b/%h/%h want 1/5/3c", wr_t, addr_t, wd_t); end
            end
        end
    endtask

    task automatic test_async_reset();
        stim_t q[$];
        q.push_back(B(8'hAA)); q.push_back(B(8'h05));
        q.push_back(B(8'hBB)); q.push_back(B(8'h03));
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                #2 rst_n = 1'b0;
                #1;
                checks++;
                if (obs_a !== 21'd0 || obs_t !== 21'd0) begin errors++; $display("FAIL async_reset: got %h/%h want 0", obs_a, obs_t); end
                @(negedge clk);
                rst_n = 1'b1;
            end
            cyc(q[i]);
            checks++;
            if (obs_a !== pack(ma)) begin errors++; $display("FAIL async_reset a[%0d]: got %h want %h", i, obs_a, pack(ma)); end
            checks++;
            if (obs_t !== pack(mt)) begin errors++; $display("FAIL async_reset t[%0d]: got %h want %h", i, obs_t, pack(mt)); end
        end
        checks++;
        if ({rd_a, addr_a, wr_a} !== {1'b1, 4'h3, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_read: got rd=%b addr=%h wr=%b want 1/3/0", rd_a, addr_a, wr_a);
        end
    endtask

    task automatic test_random();
        stim_t st;
        logic [7:0] ops [4];
        ops[0] = 8'hAA; ops[1] = 8'hBB; ops[2] = 8'hCC; ops[3] = 8'hDD;
        for (int i = 0; i < 500; i++) begin
            st = IDL;
            if ($urandom_range(0, 99) < 60) begin
                st.v = 1'b1;
                st.x = ($urandom_range(0, 99) < 40) ? ops[$urandom_range(0, 3)] : 8'($urandom);
                st.p = ($urandom_range(0, 99) < 5);
                st.s = ($urandom_range(0, 99) < 4);
            end else if ($urandom_range(0, 99) < 10) begin
                repeat ($urandom_range(10, 20)) begin
                    cyc(IDL);
                    checks++;
                    if (obs_t !== pack(mt)) begin errors++; $display("FAIL random_gap t[%0d]: got %h want %h", i, obs_t, pack(mt)); end
                end
            end
            cyc(st);
            checks++;
            if (obs_a !== pack(ma)) begin errors++; $display("FAIL random a[%0d]: got %h want %h", i, obs_a, pack(ma)); end
            checks++;
            if (obs_t !== pack(mt)) begin errors++; $display("FAIL random t[%0d]: got %h want %h", i, obs_t, pack(mt)); end
            checks++;
            if (int'(wr_a) + int'(rd_a) + int'(alu_a) > 1) begin errors++; $display("FAIL onehot_strobe[%0d]: got %b%b%b want at most one", i, wr_a, rd_a, alu_a); end
        end
    endtask

    initial begin
        test_reset();
        test_write_slow();
        test_frames();
        test_errors();
        test_timeout();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/rx_cmd_decoder.md
# rx_cmd_decoder

Command-frame decoder that sits directly downstream of the UART receiver top. It consumes the receiver's parallel byte, data-valid pulse and parity/stop error flags, and assembles multi-byte command frames. It then issues single-cycle register-file write/read strobes and ALU-enable strobes to the system back end. Errored bytes, unknown opcodes and stalled frames abort the frame and raise a frame-error pulse.

## Interface
- DATA_LENGTH, 8, width of received byte
- ADDR_WIDTH, 4, register-file address width (low bits of address byte)
- TIMEOUT_CYCLES, 4096, max CLK cycles allowed between bytes inside a frame
- CLK_CMD  in  1  system clock, same domain as the receiver
- RST_CMD  in  1  reset, asynchronous, active-low
- P_DATA_CMD  in  DATA_LENGTH  byte from receiver
- data_valid_CMD  in  1  one-cycle pulse, byte valid
- parity_error_CMD  in  1  parity error for the current byte
- stop_error_CMD  in  1  stop error for the current byte
- WrEn_CMD  out  1  register-file write strobe, one cycle
- RdEn_CMD  out  1  register-file read strobe, one cycle
- Address_CMD  out  ADDR_WIDTH  register-file address
- WrData_CMD  out  DATA_LENGTH  register-file write data
- ALU_EN_CMD  out  1  ALU enable strobe, one cycle
- ALU_FUN_CMD  out  4  ALU function code
- frame_err_CMD  out  1  one-cycle pulse, frame aborted or opcode rejected
- cmd_busy_CMD  out  1  high while a frame is in progress (state ≠ IDLE)

## Operation
- Accepted byte: data_valid_CMD=1, parity_error_CMD=0 and stop_error_CMD=0.
- Rejected byte: data_valid_CMD=1 with either error flag set.
  - In IDLE: ignored, no frame_err.
  - Mid-frame: abort to IDLE and pulse frame_err.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN.
- IDLE, accepted byte:
  - 0xAA goes to WR_ADDR.
  - 0xBB goes to RD_ADDR.
  - 0xCC goes to ALU_A.
  - 0xDD goes to ALU_FUN.
  - Any other value stays in IDLE and pulses frame_err.
- WR_ADDR: latch byte[ADDR_WIDTH-1:0] into Address; go to WR_DATA.
- WR_DATA: WrEn pulse; WrData=byte, Address=latched value; go to IDLE.
- RD_ADDR: RdEn pulse; Address=byte[ADDR_WIDTH-1:0]; go to IDLE.
- ALU_A: WrEn pulse; Address=0, WrData=byte; go to ALU_B.
- ALU_B: WrEn pulse; Address=1, WrData=byte; go to ALU_FUN.
- ALU_FUN: ALU_EN pulse; ALU_FUN=byte[3:0] (upper bits ignored); go to IDLE.
- Address, WrData and ALU_FUN hold their last value between strobes.
- Timeout counter:
  - Cleared on every accepted byte and while in IDLE.
  - Increments every cycle otherwise.
  - On reaching TIMEOUT_CYCLES-1: go to IDLE, pulse frame_err, clear the counter.
- Simultaneous events:
  - Accepted byte in the expiry cycle: the byte wins and is processed normally; no frame_err.
  - Rejected byte in the expiry cycle: exactly one frame_err pulse.
- Reset mid-frame: immediate return to IDLE, all outputs cleared, partial frame discarded.

## Timing
- All outputs are registered.
- WrEn, RdEn, ALU_EN, frame_err and the data/address outputs take their values on the CLK_CMD edge after the sampled data_valid cycle. Latency is 1 cycle.
- Every strobe is high for exactly one cycle. At most one of WrEn, RdEn, ALU_EN is high in any cycle.
- cmd_busy rises one cycle after an accepted opcode. It falls in the same cycle the final strobe is asserted, or the same cycle as frame_err.
- No back-pressure: strobes are unconditionally accepted by the back end.
- Back-to-back data_valid on consecutive cycles must be handled; the receiver never produces it, but the block must not drop bytes.
- Reset values:
  - All outputs 0.
  - State IDLE, timeout counter 0.
- Counter width: $clog2(TIMEOUT_CYCLES).

## Structure
- Shared package rx_cmd_pkg:
  - Opcode constants: WR_CMD=8'hAA, RD_CMD=8'hBB, ALU_OP_CMD=8'hCC, ALU_NOP_CMD=8'hDD.
  - State encoding.
  - ALU operand addresses: OPA_ADDR=0, OPB_ADDR=1.
- One sub-module, frame_timeout_cnt, holds the inter-byte timeout counter.
  - Inputs: clear, run.
  - Output: expire pulse.
- The FSM and output registers live in rx_cmd_decoder.

## Test plan
- Frame AA,05,3C with accepted bytes 40 cycles apart: one WrEn pulse, Address=5, WrData=0x3C, 1 cycle after the third data_valid; frame_err never asserted.
- Frame BB,09: one RdEn pulse, Address=9; cmd_busy high only between the bytes.
- Frame CC,12,34,02: WrEn with Address 0 / data 0x12, then WrEn with Address 1 / data 0x34, then ALU_EN with ALU_FUN=2. Frame DD,07: single ALU_EN with ALU_FUN=7, no WrEn.
- Byte 0x55 in IDLE: frame_err pulse, state stays IDLE. AA then a byte with parity_error=1: frame_err pulse, no WrEn; the following AA,01,FF frame succeeds.
- TIMEOUT_CYCLES=16, AA sent, then nothing: frame_err exactly 16 cycles after the AA's accept edge, cmd_busy drops. Repeat with the next byte arriving on the expiry cycle: byte processed, no frame_err.
- RST_CMD asserted asynchronously after AA,05: outputs zero immediately. After release, frame BB,03 yields RdEn with Address=3.
